// File: rtl/mmc1_bus_loader_pkg.sv
// Shared constants and FSM state type for the MMC1 bus loader.
package mmc1_pkg;

  localparam logic [1:0] SEL_CTRL = 2'b00;
  localparam logic [1:0] SEL_CHR0 = 2'b01;
  localparam logic [1:0] SEL_CHR1 = 2'b10;
  localparam logic [1:0] SEL_PRG  = 2'b11;

  localparam int unsigned LOAD_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    EVAL
  } state_t;

endpackage

// File: rtl/mmc1_bus_loader_if.sv
// Cartridge CPU bus inputs and register-write event outputs of the MMC1 loader.
interface mmc1_bus_if;
  logic       CPU_M2;
  logic       nCPU_ROMSEL;
  logic       nCPU_RW;
  logic       CPU_A14;
  logic       CPU_A13;
  logic       CPU_D0;
  logic       CPU_D7;
  logic       WR_STB;
  logic [1:0] WR_SEL;
  logic [4:0] WR_DATA;
  logic       RST_STB;
  logic [2:0] LOAD_CNT;

  modport slave (
    input  CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
    output WR_STB, WR_SEL, WR_DATA, RST_STB, LOAD_CNT
  );

  modport master (
    output CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
    input  WR_STB, WR_SEL, WR_DATA, RST_STB, LOAD_CNT
  );
endinterface

// File: rtl/mmc1_bus_loader_sync.sv
// N-stage input synchronizer; FILT>0 adds a level filter requiring FILT
// consecutive differing samples before the output follows.
module mmc1_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= {s[STAGES-2:0], d};
  end

  generate
    if (FILT == 0) begin : g_plain
      assign q = s[STAGES-1];
    end else begin : g_filt
      localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;
      logic [CW-1:0] cnt;
      logic          qf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          qf  <= 1'b0;
        end else if (s[STAGES-1] != qf) begin
          if (cnt == CW'(FILT - 1)) begin
            qf  <= s[STAGES-1];
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign q = qf;
    end
  endgenerate

endmodule

// File: rtl/mmc1_bus_loader.sv
// MMC1 bus front end: oversamples the CPU bus, runs the serial 5-bit load
// protocol and emits single-cycle register-write / reset events.
// Optional: define MMC1_CONSEC_WRITE_FILTER_EN to ignore back-to-back D7=0 writes.
module mmc1_bus_loader
  import mmc1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned M2_FILT     = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  mmc1_bus_if.slave  bus
);

  logic m2f, romsel_s, rw_s, a14_s, a13_s, d0_s, d7_s;

  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(M2_FILT)) u_m2  (.clk(CLK), .rst_n(nRST), .d(bus.CPU_M2),      .q(m2f));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_rs  (.clk(CLK), .rst_n(nRST), .d(bus.nCPU_ROMSEL), .q(romsel_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_rw  (.clk(CLK), .rst_n(nRST), .d(bus.nCPU_RW),     .q(rw_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_a14 (.clk(CLK), .rst_n(nRST), .d(bus.CPU_A14),     .q(a14_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_a13 (.clk(CLK), .rst_n(nRST), .d(bus.CPU_A13),     .q(a13_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_d0  (.clk(CLK), .rst_n(nRST), .d(bus.CPU_D0),      .q(d0_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .FILT(0))       u_d7  (.clk(CLK), .rst_n(nRST), .d(bus.CPU_D7),      .q(d7_s));

  state_t state, state_nxt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!m2f) state_nxt = LOW;
      LOW:  if (m2f)  state_nxt = HIGH;
      HIGH: if (!m2f) state_nxt = EVAL;
      EVAL:           state_nxt = LOW;
      default:        state_nxt = IDLE;
    endcase
  end

  logic                 lat_romsel_n, lat_rw_n, lat_a14, lat_a13, lat_d0, lat_d7;
  logic [LOAD_BITS-2:0] shift_reg;
  logic [2:0]           load_cnt;
  logic                 wr_stb, rst_stb;
  logic [1:0]           wr_sel;
  logic [4:0]           wr_data;
  logic                 is_write, accept;

  assign is_write = !lat_romsel_n && !lat_rw_n;

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  logic prev_wr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)               prev_wr <= 1'b0;
    else if (state == EVAL)  prev_wr <= is_write;
  end

  assign accept = !prev_wr;
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_romsel_n <= 1'b0;
      lat_rw_n     <= 1'b0;
      lat_a14      <= 1'b0;
      lat_a13      <= 1'b0;
      lat_d0       <= 1'b0;
      lat_d7       <= 1'b0;
      shift_reg    <= '0;
      load_cnt     <= '0;
      wr_stb       <= 1'b0;
      rst_stb      <= 1'b0;
      wr_sel       <= '0;
      wr_data      <= '0;
    end else begin
      wr_stb  <= 1'b0;
      rst_stb <= 1'b0;
      // Keep the last sample taken while M2 was still seen high
      if (state == HIGH && m2f) begin
        lat_romsel_n <= romsel_s;
        lat_rw_n     <= rw_s;
        lat_a14      <= a14_s;
        lat_a13      <= a13_s;
        lat_d0       <= d0_s;
        lat_d7       <= d7_s;
      end
      if (state == EVAL && is_write) begin
        if (lat_d7) begin
          shift_reg <= '0;
          load_cnt  <= '0;
          rst_stb   <= 1'b1;
        end else if (accept) begin
          if (load_cnt == 3'(LOAD_BITS - 1)) begin
            wr_data   <= {lat_d0, shift_reg};
            wr_sel    <= {lat_a14, lat_a13};
            wr_stb    <= 1'b1;
            shift_reg <= '0;
            load_cnt  <= '0;
          end else begin
            shift_reg[load_cnt[1:0]] <= lat_d0;
            load_cnt                 <= load_cnt + 3'd1;
          end
        end
      end
    end
  end

  assign bus.WR_STB   = wr_stb;
  assign bus.RST_STB  = rst_stb;
  assign bus.WR_SEL   = wr_sel;
  assign bus.WR_DATA  = wr_data;
  assign bus.LOAD_CNT = load_cnt;

endmodule

// File: tb/tb_mmc1_bus_loader.sv
// Scoreboard bench for mmc1_bus_loader: a protocol model queues expected
// strobes as each M2 cycle ends; a monitor pops and compares them.
module tb_mmc1_bus_loader;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  mmc1_bus_if bus ();

  mmc1_bus_loader #(.SYNC_STAGES(2), .M2_FILT(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       is_rst;
    logic [1:0] sel;
    logic [4:0] data;
  } ev_t;

  ev_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rst = 0, exp_wr = 0, exp_rst = 0;

  logic [2:0] m_cnt  = '0;
  logic [3:0] m_shift = '0;
  logic       m_prev = 1'b0;
  logic [4:0] m_data = '0;
  logic [1:0] m_sel  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval(input logic romsel_n, input logic rw_n, input logic a14,
                            input logic a13, input logic d0, input logic d7);
    ev_t e;
    if (!(!romsel_n && !rw_n)) begin
      m_prev = 1'b0;
    end else begin
      if (d7) begin
        m_cnt = '0;
        m_shift = '0;
        e = '{is_rst: 1'b1, sel: 2'b00, data: 5'b00000};
        sb.push_back(e);
        exp_rst++;
      end else if (!(FILT_EN && m_prev)) begin
        if (m_cnt == 3'd4) begin
          m_data = {d0, m_shift};
          m_sel  = {a14, a13};
          e = '{is_rst: 1'b0, sel: m_sel, data: m_data};
          sb.push_back(e);
          exp_wr++;
          m_cnt = '0;
          m_shift = '0;
        end else begin
          m_shift[m_cnt[1:0]] = d0;
          m_cnt = m_cnt + 3'd1;
        end
      end
      m_prev = 1'b1;
    end
  endtask

  task automatic cpu_cycle(input logic romsel_n, input logic rw_n, input logic a14,
                           input logic a13, input logic d0, input logic d7);
    @(negedge CLK);
    bus.nCPU_ROMSEL = romsel_n;
    bus.nCPU_RW     = rw_n;
    bus.CPU_A14     = a14;
    bus.CPU_A13     = a13;
    bus.CPU_D0      = d0;
    bus.CPU_D7      = d7;
    repeat (2) @(negedge CLK);
    bus.CPU_M2 = 1'b1;
    repeat (8) @(negedge CLK);
    bus.CPU_M2 = 1'b0;
    model_eval(romsel_n, rw_n, a14, a13, d0, d7);
    repeat (10) @(negedge CLK);
  endtask

  task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
    cpu_cycle(1'b0, 1'b0, a14, a13, d0, d7);
  endtask

  task automatic gap();
    cpu_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr_sep(input logic a14, input logic a13, input logic d0, input string tag);
    wr(a14, a13, d0, 1'b0);
    check(tag, bus.LOAD_CNT, m_cnt);
    gap();
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (nRST && (bus.WR_STB || bus.RST_STB)) begin
      if (bus.WR_STB) n_wr++;
      if (bus.RST_STB) n_rst++;
      check("strobe_excl", 32'(bus.WR_STB & bus.RST_STB), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'(bus.WR_STB | bus.RST_STB), 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", 32'(bus.RST_STB), 32'(e.is_rst));
        if (!e.is_rst) begin
          check("wr_sel", 32'(bus.WR_SEL), 32'(e.sel));
          check("wr_data", 32'(bus.WR_DATA), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CPU_M2 = 1'b0;
    bus.nCPU_ROMSEL = 1'b1;
    bus.nCPU_RW = 1'b1;
    bus.CPU_A14 = 1'b0;
    bus.CPU_A13 = 1'b0;
    bus.CPU_D0 = 1'b0;
    bus.CPU_D7 = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_wr_stb",  32'(bus.WR_STB),   32'd0);
    check("rst_rst_stb", 32'(bus.RST_STB),  32'd0);
    check("rst_wr_data", 32'(bus.WR_DATA),  32'd0);
    check("rst_wr_sel",  32'(bus.WR_SEL),   32'd0);
    check("rst_cnt",     32'(bus.LOAD_CNT), 32'd0);
    nRST = 1'b1;
    repeat (4) @(negedge CLK);

    // $8000, D0 = 1,0,1,1,0 -> CTRL 5'b01101
    gap();
    wr_sep(1'b0, 1'b0, 1'b1, "t1_cnt");
    wr_sep(1'b0, 1'b0, 1'b0, "t1_cnt");
    wr_sep(1'b0, 1'b0, 1'b1, "t1_cnt");
    wr_sep(1'b0, 1'b0, 1'b1, "t1_cnt");
    wr_sep(1'b0, 1'b0, 1'b0, "t1_cnt");
    check("t1_data_hold", 32'(bus.WR_DATA), 32'h0D);
    check("t1_sel_hold",  32'(bus.WR_SEL),  32'd0);

    // Partial load aborted by D7, then $E000 all ones
    wr_sep(1'b1, 1'b1, 1'b1, "t2_cnt");
    wr_sep(1'b1, 1'b1, 1'b0, "t2_cnt");
    wr_sep(1'b1, 1'b1, 1'b1, "t2_cnt");
    wr(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_d7_cnt", 32'(bus.LOAD_CNT), 32'd0);
    gap();
    for (int i = 0; i < 5; i++) wr_sep(1'b1, 1'b1, 1'b1, "t2b_cnt");
    check("t2_data_hold", 32'(bus.WR_DATA), 32'h1F);
    check("t2_sel_hold",  32'(bus.WR_SEL),  32'd3);

    // Reads and non-ROM writes leave the load untouched
    wr_sep(1'b0, 1'b1, 1'b1, "t4_cnt");
    wr_sep(1'b0, 1'b1, 1'b0, "t4_cnt");
    cpu_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cpu_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cpu_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t4_cnt_kept", 32'(bus.LOAD_CNT), 32'd2);

    // Reset after four writes discards the partial load
    wr_sep(1'b0, 1'b1, 1'b1, "t5_cnt");
    wr_sep(1'b0, 1'b1, 1'b1, "t5_cnt");
    check("t5_cnt4", 32'(bus.LOAD_CNT), 32'd4);
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check("t5_wr_data", 32'(bus.WR_DATA),  32'd0);
    check("t5_wr_sel",  32'(bus.WR_SEL),   32'd0);
    check("t5_cnt",     32'(bus.LOAD_CNT), 32'd0);
    m_cnt = '0;
    m_shift = '0;
    m_prev = 1'b0;
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    wr_sep(1'b1, 1'b0, 1'b0, "t5b_cnt");
    wr_sep(1'b1, 1'b0, 1'b1, "t5b_cnt");
    wr_sep(1'b1, 1'b0, 1'b1, "t5b_cnt");
    wr_sep(1'b1, 1'b0, 1'b0, "t5b_cnt");
    wr_sep(1'b1, 1'b0, 1'b1, "t5b_cnt");

    // Back-to-back writes
    gap();
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_b2b_cnt", 32'(bus.LOAD_CNT), FILT_EN ? 32'd1 : 32'd2);
    gap();

    // One-CLK M2 glitch during a write pattern
    @(negedge CLK);
    bus.nCPU_ROMSEL = 1'b0;
    bus.nCPU_RW = 1'b0;
    bus.CPU_D0 = 1'b1;
    bus.CPU_D7 = 1'b0;
    repeat (2) @(negedge CLK);
    bus.CPU_M2 = 1'b1;
    @(negedge CLK);
    bus.CPU_M2 = 1'b0;
    repeat (12) @(negedge CLK);
    check("t6_glitch_cnt", 32'(bus.LOAD_CNT), 32'(m_cnt));
    gap();
    wr_sep(1'b0, 1'b0, 1'b0, "t6_cnt");

    repeat (20) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("wr_strobes", 32'(n_wr), 32'(exp_wr));
    check("rst_strobes", 32'(n_rst), 32'(exp_rst));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
